lc3_pipe_controller: RTL
========================

// Module: lc3_pipe_controller
// PURPOSE
//  Pipeline controller for the LC3 core. Sequences per-stage enables (updatePC/fetch/decode/execute/writeback).
//  Runs the data-memory access FSM and stalls the front end during loads/stores.
//  Inserts control-hazard bubbles for BR/JMP and decides branch outcome.
//  Raises ALU/memory bypass selects from the decode-stage IR vs the execute-stage IR.
//  Sits beside the decode stage; consumes the decode_out IR and the execute-stage IR.
// PARAMETERS
//  BR_STALL_CYCLES  3  front-end bubble cycles after a BR/JMP leaves decode (1..7)
//  FILL_STAGES      4  stages after fetch enabled one per cycle after reset (fixed by pipeline depth)
// PORTS
//  clock            in   1   core clock, all state on rising edge
//  reset            in   1   asynchronous, active-low; 0 = in reset
//  complete_instr   in   1   instruction memory response valid; 0 freezes all enables
//  complete_data    in   1   data memory access done (one-cycle pulse)
//  IR               in   16  instruction in decode (decode_out IR)
//  IR_Exec          in   16  instruction in execute
//  psr              in   3   current N,Z,P flags
//  enable_updatePC  out  1   PC register load enable
//  enable_fetch     out  1   fetch stage enable
//  enable_decode    out  1   decode stage enable
//  enable_execute   out  1   execute stage enable
//  enable_writeback out  1   writeback stage enable
//  br_taken         out  1   take branch/jump target this cycle
//  mem_state        out  2   11 IDLE, 00 READ, 01 INDIRECT, 10 WRITE
//  bypass_alu_1/2   out  1   SR1/SR2 take execute-stage ALU result
//  bypass_mem_1/2   out  1   SR1/SR2 take memory read data
// BEHAVIOUR
//  Reset (reset=0): all enables 0, br_taken 0, bypasses 0, mem_state 11, bubble counter 0, fill register 0.
//  Fill: after reset rises, updatePC+fetch go 1 on 1st edge, decode on 2nd, execute on 3rd, writeback on 4th;
//   5-bit fill shift register, LSB first. Fill state sticks until next reset.
//  Opcodes IR[15:12]: ADD 0001, AND 0101, NOT 1001, LEA 1110, BR 0000, JMP 1100,
//   LD 0010, LDR 0110, LDI 1010, ST 0011, STR 0111, STI 1011.
//  Mem FSM (registered): IDLE->READ on IR_Exec LD/LDR; IDLE->WRITE on ST/STR;
//   IDLE->INDIRECT on LDI/STI. INDIRECT->READ (LDI) or WRITE (STI) on complete_data.
//   READ/WRITE->IDLE on complete_data; no timeout.
//  Mem stall: while mem_state!=IDLE, updatePC/fetch/decode/execute = 0.
//   enable_writeback=0 except the READ cycle where complete_data=1, which gives writeback=1.
//  Control hazard: IR is BR or JMP with decode enabled -> bubble counter loads BR_STALL_CYCLES.
//   While counter!=0, updatePC/fetch/decode = 0. Counter decrements each unfrozen cycle.
//  br_taken (combinational): IR_Exec JMP, or IR_Exec BR with |(IR_Exec[11:9] & psr).
//   Gated by enable_execute. br_taken forces enable_updatePC=1 that cycle.
//  Bypass (combinational; all 0 unless enable_execute):
//   dest = IR_Exec[11:9]. sr1 = IR[8:6]. sr2 = IR[2:0], used only for ADD/AND with IR[5]=0.
//   bypass_alu_1: IR_Exec in {ADD,AND,NOT,LEA}, IR reads sr1 (ALU ops, LDR, STR, JMP), sr1==dest.
//   bypass_alu_2: same producer set, sr2 used, sr2==dest.
//   bypass_mem_1/2: same matching, producer in {LD,LDR,LDI}.
//   Store source IR[11:9] is never bypassed.
//  Freeze: complete_instr=0 forces all five enables 0; FSM and counters hold.
//   Exception: complete_data still advances the mem FSM.
//  Simultaneous events: a mem stall takes priority over a bubble decrement; the counter holds during a mem stall.
//   BR in decode while a mem op starts: counter loads only when decode is actually enabled.
//  Reset mid-operation: immediate return to reset values. A pending memory access is abandoned.
// TESTING
//  Release reset, complete_instr=1, IR=ADD -> fetch/updatePC=1 at edge1, decode edge2, execute edge3, writeback edge4.
//  IR_Exec=LDR, complete_data at cycle+3 -> mem_state 00 for 3 cycles; front enables 0; writeback=1 on done cycle;
//   then mem_state returns to 11.
//  IR_Exec=LDI (0xA200), two complete_data pulses -> mem_state 11->01->00->11; stall spans both accesses.
//  IR=BR nzp=010 then IR_Exec=same, psr=010 -> 3 fetch bubbles; br_taken=1 one cycle. With psr=001: br_taken=0.
//  IR_Exec=ADD R3 (0x16C2), IR=ADD R1,R3,R3 (0x12C3) -> bypass_alu_1=1, bypass_alu_2=1.
//   IR_Exec=LD R3 instead -> bypass_mem_1/2=1.
//  Drive reset=0 mid READ state -> mem_state=11 and all enables 0 asynchronously; fill restarts after release.

Source files
------------

// File: rtl/lc3_pipe_controller_if.sv
// ---------------------------------------------------------------------------
// lc3_pipe_controller_if
// Bundles the signals between the LC3 pipeline controller and the rest of
// the core.
//   Core -> controller : complete_instr, complete_data, IR, IR_Exec, psr
//   Controller -> core : enable_updatePC/fetch/decode/execute/writeback,
//                        br_taken, mem_state, bypass_alu_1/2, bypass_mem_1/2
// Modports: master = core side (drives status), slave = controller side.
// ---------------------------------------------------------------------------
interface lc3_pipe_controller_if;
    logic        complete_instr;
    logic        complete_data;
    logic [15:0] IR;
    logic [15:0] IR_Exec;
    logic [2:0]  psr;

    logic        enable_updatePC;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        br_taken;
    logic [1:0]  mem_state;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic        bypass_mem_1;
    logic        bypass_mem_2;

    modport master (
        output complete_instr, complete_data, IR, IR_Exec, psr,
        input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, br_taken, mem_state,
               bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2
    );

    modport slave (
        input  complete_instr, complete_data, IR, IR_Exec, psr,
        output enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, br_taken, mem_state,
               bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2
    );
endinterface

// File: rtl/lc3_pipe_controller.sv
// ---------------------------------------------------------------------------
// lc3_pipe_controller
// Pipeline controller for the LC3 core: per-stage enables with post-reset
// fill, data-memory access FSM with front-end stall, control-hazard bubbles
// and branch decision for BR/JMP, and ALU/memory bypass selects.
// Ports:
//   clock  in  core clock, rising edge
//   reset  in  asynchronous, active-low
//   ctrl   slave modport of lc3_pipe_controller_if (status in, enables out)
// ---------------------------------------------------------------------------
module lc3_pipe_controller #(
    parameter int unsigned BR_STALL_CYCLES = 3   // 1..7
) (
    input  logic                  clock,
    input  logic                  reset,
    lc3_pipe_controller_if.slave  ctrl
);
    // Stages after fetch that come alive one per cycle after reset.
    localparam int FILL_STAGES = 4;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    typedef enum logic [1:0] {
        MEM_READ     = 2'b00,
        MEM_INDIRECT = 2'b01,
        MEM_WRITE    = 2'b10,
        MEM_IDLE     = 2'b11
    } mem_state_t;

    mem_state_t           mem_state_q, mem_state_d;
    logic                 ind_store_q, ind_store_d;   // INDIRECT belongs to an STI
    logic [2:0]           bubble_q, bubble_d;
    logic [FILL_STAGES:0] fill_q, fill_d;             // [0]PC [1]fetch [2]dec [3]exe [4]wb

    logic [3:0] op_dec, op_exec;
    logic [2:0] dest, sr1, sr2;
    logic       run, mem_busy, bubble_active;
    logic       en_pc, en_fetch, en_dec, en_exec, en_wb, br_take;
    logic       prod_alu, prod_mem, reads_sr1, reads_sr2, match1, match2;
    logic       unused_bits;

    assign op_dec  = ctrl.IR[15:12];
    assign op_exec = ctrl.IR_Exec[15:12];
    assign dest    = ctrl.IR_Exec[11:9];
    assign sr1     = ctrl.IR[8:6];
    assign sr2     = ctrl.IR[2:0];
    // Store source (IR[11:9]) is deliberately never compared.
    assign unused_bits = ^{ctrl.IR[11:9], ctrl.IR[4:3], ctrl.IR_Exec[8:0]};

    assign run           = ctrl.complete_instr;
    assign mem_busy      = (mem_state_q != MEM_IDLE);
    assign bubble_active = (bubble_q != 3'd0);

    assign en_exec = run & fill_q[3] & ~mem_busy;
    assign br_take = en_exec & ((op_exec == OP_JMP) |
                     ((op_exec == OP_BR) & |(ctrl.IR_Exec[11:9] & ctrl.psr)));
    // A taken branch must load the target even while the front end is bubbled.
    assign en_pc    = (run & fill_q[0] & ~mem_busy & ~bubble_active) | br_take;
    assign en_fetch = run & fill_q[1] & ~mem_busy & ~bubble_active;
    assign en_dec   = run & fill_q[2] & ~mem_busy & ~bubble_active;
    // Writeback resumes for the load result on the cycle the read completes.
    assign en_wb    = run & fill_q[4] &
                      (~mem_busy | ((mem_state_q == MEM_READ) & ctrl.complete_data));

    // Bypass selects
    assign prod_alu  = (op_exec == OP_ADD) | (op_exec == OP_AND) |
                       (op_exec == OP_NOT) | (op_exec == OP_LEA);
    assign prod_mem  = (op_exec == OP_LD) | (op_exec == OP_LDR) | (op_exec == OP_LDI);
    assign reads_sr1 = (op_dec == OP_ADD) | (op_dec == OP_AND) | (op_dec == OP_NOT) |
                       (op_dec == OP_LDR) | (op_dec == OP_STR) | (op_dec == OP_JMP);
    assign reads_sr2 = ((op_dec == OP_ADD) | (op_dec == OP_AND)) & ~ctrl.IR[5];
    assign match1    = en_exec & reads_sr1 & (sr1 == dest);
    assign match2    = en_exec & reads_sr2 & (sr2 == dest);

    assign ctrl.enable_updatePC  = en_pc;
    assign ctrl.enable_fetch     = en_fetch;
    assign ctrl.enable_decode    = en_dec;
    assign ctrl.enable_execute   = en_exec;
    assign ctrl.enable_writeback = en_wb;
    assign ctrl.br_taken         = br_take;
    assign ctrl.mem_state        = mem_state_q;
    assign ctrl.bypass_alu_1     = match1 & prod_alu;
    assign ctrl.bypass_alu_2     = match2 & prod_alu;
    assign ctrl.bypass_mem_1     = match1 & prod_mem;
    assign ctrl.bypass_mem_2     = match2 & prod_mem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_state_q <= MEM_IDLE;
            ind_store_q <= 1'b0;
            bubble_q    <= 3'd0;
            fill_q      <= '0;
        end else begin
            mem_state_q <= mem_state_d;
            ind_store_q <= ind_store_d;
            bubble_q    <= bubble_d;
            fill_q      <= fill_d;
        end
    end

    always_comb begin
        mem_state_d = mem_state_q;
        ind_store_d = ind_store_q;
        bubble_d    = bubble_q;
        fill_d      = fill_q;

        // PC and fetch come up together, then one stage per cycle.
        if (run) begin
            fill_d = {fill_q[FILL_STAGES-1:1], 2'b11};
        end

        // Only a BR/JMP actually accepted by decode arms the bubble; a mem
        // stall freezes the count.
        if (en_dec && ((op_dec == OP_BR) || (op_dec == OP_JMP))) begin
            bubble_d = 3'(BR_STALL_CYCLES);
        end else if (run && !mem_busy && bubble_active) begin
            bubble_d = bubble_q - 3'd1;
        end

        // complete_data advances the FSM even while the front end is frozen.
        unique case (mem_state_q)
            MEM_IDLE: begin
                if (en_exec) begin
                    unique case (op_exec)
                        OP_LD, OP_LDR: mem_state_d = MEM_READ;
                        OP_ST, OP_STR: mem_state_d = MEM_WRITE;
                        OP_LDI: begin
                            mem_state_d = MEM_INDIRECT;
                            ind_store_d = 1'b0;
                        end
                        OP_STI: begin
                            mem_state_d = MEM_INDIRECT;
                            ind_store_d = 1'b1;
                        end
                        default: mem_state_d = MEM_IDLE;
                    endcase
                end
            end
            MEM_INDIRECT: begin
                if (ctrl.complete_data) begin
                    mem_state_d = ind_store_q ? MEM_WRITE : MEM_READ;
                end
            end
            MEM_READ, MEM_WRITE: begin
                if (ctrl.complete_data) begin
                    mem_state_d = MEM_IDLE;
                end
            end
            default: mem_state_d = MEM_IDLE;
        endcase
    end
endmodule
